// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 4-bit ALU and the stages around it.
//   - alu_op_e      : opcode encodings produced alongside each ALU result
//   - FLG_*         : bit positions of N, Z, C, V inside a 4-bit flag vector
//   - entry_width() : width of one buffered result {opcode, data, flags}
//   - alu_entry_t   : the same layout spelled out for the default 4-bit datapath
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_AND = 4'b0001,
        OP_OR  = 4'b0010,
        OP_NOT = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SLL = 4'b0101,
        OP_SRA = 4'b0110,
        OP_SRL = 4'b0111,
        OP_ADD = 4'b1000,
        OP_SUB = 4'b1001
    } alu_op_e;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    localparam int OPC_W = 4;
    localparam int FLG_W = 4;

    // Entry layout, MSB to LSB: opcode, data, flags.
    function automatic int entry_width(input int data_w);
        return OPC_W + data_w + FLG_W;
    endfunction

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [3:0]       data;
        logic [FLG_W-1:0] flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
// Generic first-word-fall-through FIFO with exact occupancy count.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push, wr_data : write request and data (ignored while full)
//   pop           : consume head entry (ignored while empty)
//   rd_data       : head entry, zero while empty
//   full, empty   : occupancy status
//   count         : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_q;

    // Head is presented combinationally; forced to zero when empty so stale
    // storage never leaks out.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
// Captures ALU results and flags on a valid/ready handshake, keeps the
// architectural flag register (its carry feeds back as ALU Cin) and buffers
// results in a FWFT FIFO for the writeback consumer.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   in_valid/in_ready           : producer handshake from the ALU
//   in_opcode, in_y, in_n..in_v : result, opcode and flags of this ALU op
//   flags_clr                   : synchronous clear of the flag register
//   cin_out                     : registered carry, to ALU Cin
//   flags                       : flag register {N,Z,C,V}
//   out_valid/out_ready         : consumer handshake
//   out_data/out_opcode/out_flags : head entry
//   count                       : FIFO occupancy
//   sticky_v                    : sticky overflow
// Build option: ALU_RESULT_STAGE_STICKY_OVF_EN enables the sticky overflow
// register; otherwise sticky_v is constant 0.
// -----------------------------------------------------------------------------
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [DATA_W-1:0] in_y,
    input  logic              in_n,
    input  logic              in_z,
    input  logic              in_c,
    input  logic              in_v,
    input  logic              flags_clr,
    output logic              cin_out,
    output logic [3:0]        flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_opcode,
    output logic [3:0]        out_flags,
    output logic [CNT_W-1:0]  count,
    output logic              sticky_v
);

    localparam int ENTRY_W = entry_width(DATA_W);

    logic               fifo_full;
    logic               fifo_empty;
    logic               push_hs;
    logic               store;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic [3:0]         flags_q, flags_d;

    assign in_ready  = ~fifo_full;
    assign out_valid = ~fifo_empty;
    assign push_hs   = in_valid & in_ready;
    // NOP results complete the handshake but are dropped here.
    assign store     = push_hs & (in_opcode != OP_NOP);
    assign fifo_pop  = out_valid & out_ready;
    assign wr_entry  = {in_opcode, in_y, in_n, in_z, in_c, in_v};

    alu_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (store),
        .wr_data (wr_entry),
        .pop     (fifo_pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign out_opcode = rd_entry[ENTRY_W-1 -: OPC_W];
    assign out_data   = rd_entry[FLG_W +: DATA_W];
    assign out_flags  = rd_entry[FLG_W-1:0];

    // Flag register: clear has priority; carry only follows add-with-carry so
    // logic ops between the nibbles of a multi-nibble add keep the chain intact.
    always_comb begin
        flags_d = flags_q;
        if (flags_clr) begin
            flags_d = '0;
        end else if (store) begin
            flags_d[FLG_N] = in_n;
            flags_d[FLG_Z] = in_z;
            flags_d[FLG_V] = in_v;
            if (in_opcode == OP_ADD) begin
                flags_d[FLG_C] = in_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags   = flags_q;
    assign cin_out = flags_q[FLG_C];

`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
    logic sticky_q, sticky_d;

    // Set by any stored overflow, held until flag clear; clear wins a tie.
    always_comb begin
        sticky_d = sticky_q;
        if (flags_clr) begin
            sticky_d = 1'b0;
        end else if (store && in_v) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_v = sticky_q;
`else
    assign sticky_v = 1'b0;
`endif

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Stage directly downstream of the 4-bit ALU. Captures each ALU result (Y) and its flags (N, Z, C, V) on a valid/ready handshake.
- Holds an architectural flag register and feeds its carry back as the ALU Cin, so multi-nibble add chains work.
- Buffers results in a small FIFO so the consuming writeback logic can stall without losing ALU outputs.

Parameters:
- DATA_W, 4, width of the ALU result Y and of each FIFO data entry
- DEPTH, 4, number of FIFO entries; must be a power of two, at least 2
- CNT_W, 3, width of the occupancy count; equals log2(DEPTH)+1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ALU output valid this cycle
- in_ready  out  1  stage can accept a result
- in_opcode  in  4  opcode that produced the result
- in_y  in  DATA_W  ALU result Y
- in_n, in_z, in_c, in_v  in  1 each  ALU flags
- flags_clr  in  1  synchronous clear of the flag register
- cin_out  out  1  carry flag, wired to the ALU Cin
- flags  out  4  architectural flag register {N,Z,C,V}
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer accepts the head entry
- out_data  out  DATA_W  head result
- out_opcode  out  4  head opcode
- out_flags  out  4  head flags {N,Z,C,V}
- count  out  CNT_W  FIFO occupancy
- sticky_v  out  1  sticky overflow; see Optional Feature

Behaviour:
- Reset (async assert, sync release): FIFO empty; count=0; out_valid=0; out_data/out_opcode/out_flags=0; flags=4'b0000; cin_out=0; sticky_v=0; in_ready=1 on the first cycle after release.
- Handshake:
  - push = in_valid & in_ready; in_ready = (count != DEPTH).
  - pop = out_valid & out_ready; out_valid = (count != 0).
- Opcode 4'b0000 (ALU default/NOP): handshake completes, but nothing is stored and the flags are unchanged.
- FIFO:
  - First-word-fall-through. A push into an empty FIFO shows out_valid=1 with that entry on the next cycle (latency 1).
  - Entries leave in push order. Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle: count unchanged, both take effect.
  - When full, in_ready=0, so no push is possible even if a pop occurs in that cycle. in_ready rises the cycle after the pop.
- Flag register update, on a push with a non-NOP opcode:
  - N, Z, V are loaded for every such opcode.
  - C is loaded only for opcode 4'b1000 (add with carry); for every other opcode C holds.
- flags_clr:
  - Zeroes the flag register on the next edge.
  - If a push occurs in the same cycle, flags_clr wins for the flag register, but the pushed entry still carries its own in_* flags into the FIFO.
- cin_out equals the registered C flag, so the ALU sees the updated carry one cycle after the add is accepted.
- count is exact at all times: 0..DEPTH, never wraps.
- Reset asserted mid-stream: all entries are discarded immediately and outputs go to their reset values.

Optional Feature:
- Macro: ALU_RESULT_STAGE_STICKY_OVF_EN
- Defined:
  - sticky_v sets on any non-NOP push with in_v=1 and stays set until flags_clr or rst.
  - If flags_clr and a V=1 push occur in the same cycle, the clear wins.
- Undefined: sticky_v is tied to 0 and no register is inferred.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants: OP_NOP=0000, OP_AND=0001, OP_OR=0010, OP_NOT=0011, OP_XOR=0100, OP_SLL=0101, OP_SRA=0110, OP_SRL=0111, OP_ADD=1000, OP_SUB=1001
  - flag bit indices: FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0
  - the entry layout: opcode + data + flags, 12 bits at default width
- One natural sub-module, alu_result_fifo: a generic FWFT FIFO with pointers and count. The flag register and the NOP filter stay in the top level.

Test Plan:
- Reset: pulse rst mid-cycle with 3 entries queued -> count=0, out_valid=0, flags=0000, cin_out=0 immediately, without waiting for a clock edge.
- Add carry chain: push opcode 1000, y=0010, c=1 -> cin_out=1 on the next cycle. Then push opcode 0001, c=0 -> cin_out stays 1 (C held).
- Fill to full: hold out_ready=0 and push 4 entries (y=1,2,3,4) -> count=4, in_ready=0, and a fifth in_valid is not accepted. Then pop 4 -> out_data sequence 1,2,3,4, then out_valid=0.
- Simultaneous push/pop: with count=2, push and pop in the same cycle -> count stays 2 and ordering is preserved.
- NOP filter plus clear:
  - push opcode 0000 with n=1 -> count and flags unchanged.
  - assert flags_clr together with a push of opcode 1001, n=1 -> flags=0000, while the FIFO entry's out_flags has N=1.
- Sticky overflow (macro defined): push v=1, then v=0 -> sticky_v=1 throughout. Assert flags_clr -> sticky_v=0. With the macro undefined, sticky_v=0 always.
